// File: rtl/phase_cmd_pkg.sv
// rtl/phase_cmd_pkg.sv - shared types and constants for the phase-code command arbiter
package phase_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WAIT_GEN,
      ST_LOAD,
      ST_ECHO,
      ST_HOLD
   } state_t;

   localparam logic       SRC_UART       = 1'b0;
   localparam logic       SRC_IR         = 1'b1;
   localparam logic [7:0] DEF_MAX_CODE   = 8'd63;
   localparam logic [7:0] DEF_RESET_CODE = 8'd0;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/cmd_slot.sv
// rtl/cmd_slot.sv - one-entry pending command slot with overwrite detect and consume
module cmd_slot (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   input  logic       i_grant,
   output logic       o_flag,
   output logic [7:0] o_data,
   output logic       o_drop
);

   logic       r_flag;
   logic [7:0] r_data;

   // A strobe landing on the grant cycle replaces consumed data, so it is not a drop.
   assign o_drop = i_valid & r_flag & ~i_grant;
   assign o_flag = r_flag;
   assign o_data = r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flag <= 1'b0;
         r_data <= 8'h00;
      end else if (i_valid) begin
         r_flag <= 1'b1;
         r_data <= i_data;
      end else if (i_grant) begin
         r_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/phase_cmd_arbiter.sv
// rtl/phase_cmd_arbiter.sv - round-robin UART/IR phase-code arbiter; PHASE_CMD_ECHO_EN adds UART echo
module phase_cmd_arbiter
   import phase_cmd_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYC = 100000,
   parameter logic [7:0]  MAX_CODE    = DEF_MAX_CODE,
   parameter logic [7:0]  RESET_CODE  = DEF_RESET_CODE
) (
   input  logic       sys_clk,
   input  logic       sys_rstn,
   input  logic       uart_valid,
   input  logic [7:0] uart_data,
   input  logic       ir_valid,
   input  logic [7:0] ir_code,
   input  logic       gen_busy,
   output logic [7:0] code_out,
   output logic       code_load,
   output logic       last_src,
   output logic       err_pulse,
   output logic [7:0] drop_cnt,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   localparam int         CW        = $clog2(HOLDOFF_CYC + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);

   state_t        r_state;
   logic [7:0]    r_code;
   logic          r_src;
   logic [7:0]    r_code_out;
   logic          r_last_src;
   logic          r_code_load;
   logic          r_err_pulse;
   logic [7:0]    r_drop_cnt;
   logic [CW-1:0] r_hold_cnt;

   logic       w_idle, w_grant_uart, w_grant_ir;
   logic       w_uart_flag, w_ir_flag, w_uart_drop, w_ir_drop;
   logic [7:0] w_uart_data, w_ir_data;

   cmd_slot u_uart_slot (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rstn),
      .i_valid (uart_valid),
      .i_data  (uart_data),
      .i_grant (w_grant_uart),
      .o_flag  (w_uart_flag),
      .o_data  (w_uart_data),
      .o_drop  (w_uart_drop)
   );

   cmd_slot u_ir_slot (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rstn),
      .i_valid (ir_valid),
      .i_data  (ir_code),
      .i_grant (w_grant_ir),
      .o_flag  (w_ir_flag),
      .o_data  (w_ir_data),
      .o_drop  (w_ir_drop)
   );

   // With both pending, the source that did not load last wins.
   assign w_idle       = (r_state == ST_IDLE);
   assign w_grant_uart = w_idle & w_uart_flag & (~w_ir_flag | (r_last_src == SRC_IR));
   assign w_grant_ir   = w_idle & w_ir_flag & (~w_uart_flag | (r_last_src == SRC_UART));

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_drop_cnt <= 8'h00;
      end else begin
         r_drop_cnt <= sat_add8(r_drop_cnt, {1'b0, w_uart_drop} + {1'b0, w_ir_drop});
      end
   end

`ifdef PHASE_CMD_ECHO_EN
   logic       r_tx_start;
   logic [7:0] r_tx_data;
`endif

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_state     <= ST_IDLE;
         r_code      <= 8'h00;
         r_src       <= SRC_UART;
         r_code_out  <= RESET_CODE;
         r_last_src  <= SRC_IR;
         r_code_load <= 1'b0;
         r_err_pulse <= 1'b0;
         r_hold_cnt  <= '0;
`ifdef PHASE_CMD_ECHO_EN
         r_tx_start  <= 1'b0;
         r_tx_data   <= 8'h00;
`endif
      end else begin
         r_code_load <= 1'b0;
         r_err_pulse <= 1'b0;
`ifdef PHASE_CMD_ECHO_EN
         r_tx_start  <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_grant_uart) begin
                  r_code  <= w_uart_data;
                  r_src   <= SRC_UART;
                  r_state <= ST_CHECK;
               end else if (w_grant_ir) begin
                  r_code  <= w_ir_data;
                  r_src   <= SRC_IR;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (r_code > MAX_CODE) begin
                  r_err_pulse <= 1'b1;
                  r_state     <= ST_IDLE;
               end else if (r_code == r_code_out) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT_GEN;
               end
            end
            // Output registers update here so code_load is visible during LOAD.
            ST_WAIT_GEN: begin
               if (!gen_busy) begin
                  r_code_out  <= r_code;
                  r_last_src  <= r_src;
                  r_code_load <= 1'b1;
                  r_state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_hold_cnt <= '0;
`ifdef PHASE_CMD_ECHO_EN
               r_state    <= ST_ECHO;
`else
               r_state    <= ST_HOLD;
`endif
            end
`ifdef PHASE_CMD_ECHO_EN
            ST_ECHO: begin
               if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= r_code;
                  r_state    <= ST_HOLD;
               end
            end
`endif
            ST_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign code_out  = r_code_out;
   assign code_load = r_code_load;
   assign last_src  = r_last_src;
   assign err_pulse = r_err_pulse;
   assign drop_cnt  = r_drop_cnt;

`ifdef PHASE_CMD_ECHO_EN
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
`else
   logic w_unused_tx_busy;
   assign w_unused_tx_busy = tx_busy;
   assign tx_start = 1'b0;
   assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_phase_cmd_arbiter.sv
// tb/tb_phase_cmd_arbiter.sv - directed self-checking bench for phase_cmd_arbiter
module tb_phase_cmd_arbiter;

   localparam int H = 10;
`ifdef PHASE_CMD_ECHO_EN
   localparam int ECHO_X = 1;
`else
   localparam int ECHO_X = 0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rstn = 1'b0;
   logic       uart_valid = 1'b0;
   logic [7:0] uart_data = 8'h00;
   logic       ir_valid = 1'b0;
   logic [7:0] ir_code = 8'h00;
   logic       gen_busy = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] code_out;
   logic       code_load;
   logic       last_src;
   logic       err_pulse;
   logic [7:0] drop_cnt;
   logic       tx_start;
   logic [7:0] tx_data;

   int n_cmp = 0;
   int n_fail = 0;
   int load_cnt = 0;
   int err_cnt = 0;
   int txs_cnt = 0;
   int n0;
   int e0;
   int cyc;

   phase_cmd_arbiter #(
      .HOLDOFF_CYC (H),
      .MAX_CODE    (8'd63),
      .RESET_CODE  (8'd0)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rstn   (sys_rstn),
      .uart_valid (uart_valid),
      .uart_data  (uart_data),
      .ir_valid   (ir_valid),
      .ir_code    (ir_code),
      .gen_busy   (gen_busy),
      .code_out   (code_out),
      .code_load  (code_load),
      .last_src   (last_src),
      .err_pulse  (err_pulse),
      .drop_cnt   (drop_cnt),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (code_load) load_cnt++;
      if (err_pulse) err_cnt++;
      if (tx_start)  txs_cnt++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_load(input string tag, input int bound, output int c);
      c = 0;
      while (!code_load && c < bound) begin
         step();
         c++;
      end
      check(tag, {31'b0, code_load}, 32'd1);
   endtask

   task automatic send_uart(input logic [7:0] d);
      uart_valid = 1'b1;
      uart_data  = d;
      step();
      uart_valid = 1'b0;
   endtask

   task automatic send_ir(input logic [7:0] d);
      ir_valid = 1'b1;
      ir_code  = d;
      step();
      ir_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      step(3);
      check("rst_code_out", 32'(code_out), 32'h00);
      check("rst_code_load", 32'(code_load), 32'd0);
      check("rst_last_src", 32'(last_src), 32'd1);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      sys_rstn = 1'b1;
      step(2);

      send_uart(8'h05);
      step(2);
      check("t1_no_load_n3", 32'(code_load), 32'd0);
      step();
      check("t1_load_n4", 32'(code_load), 32'd1);
      check("t1_code_out", 32'(code_out), 32'h05);
      check("t1_last_src", 32'(last_src), 32'd0);
      step();
      check("t1_load_pulse_end", 32'(code_load), 32'd0);

      sys_rstn = 1'b0;
      step(2);
      check("t2_rst_code_out", 32'(code_out), 32'h00);
      check("t2_rst_last_src", 32'(last_src), 32'd1);
      sys_rstn = 1'b1;
      step(2);
      uart_valid = 1'b1; uart_data = 8'h07;
      ir_valid   = 1'b1; ir_code   = 8'h09;
      step();
      uart_valid = 1'b0; ir_valid = 1'b0;
      step(3);
      check("t2_uart_load", 32'(code_load), 32'd1);
      check("t2_uart_code", 32'(code_out), 32'h07);
      check("t2_uart_src", 32'(last_src), 32'd0);
      step(13 + ECHO_X);
      check("t2_holdoff_no_load", 32'(code_load), 32'd0);
      step();
      check("t2_ir_load", 32'(code_load), 32'd1);
      check("t2_ir_code", 32'(code_out), 32'h09);
      check("t2_ir_src", 32'(last_src), 32'd1);

      step(20);
      n0 = load_cnt;
      e0 = err_cnt;
      send_ir(8'h80);
      step(2);
      check("t3_err_pulse", 32'(err_pulse), 32'd1);
      step();
      check("t3_err_pulse_end", 32'(err_pulse), 32'd0);
      check("t3_code_kept", 32'(code_out), 32'h09);
      step(10);
      check("t3_no_load", 32'(load_cnt - n0), 32'd0);
      check("t3_err_once", 32'(err_cnt - e0), 32'd1);

      send_uart(8'h05);
      step(3);
      check("t4_pre_load", 32'(code_out), 32'h05);
      send_uart(8'h01);
      send_uart(8'h02);
      send_uart(8'h03);
      step();
      check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
      n0 = load_cnt;
      wait_load("t4_wait_load", 40, cyc);
      check("t4_code_03", 32'(code_out), 32'h03);
      step();
      check("t4_single_load", 32'(load_cnt - n0), 32'd1);
      step(20);
      n0 = load_cnt;
      send_uart(8'h03);
      step(15);
      check("t4_same_no_load", 32'(load_cnt - n0), 32'd0);
      check("t4_same_code", 32'(code_out), 32'h03);
      check("t4_drop_kept", 32'(drop_cnt), 32'd2);

      step(5);
      gen_busy = 1'b1;
      send_uart(8'h11);
      n0 = load_cnt;
      step(20);
      check("t5_busy_no_load", 32'(load_cnt - n0), 32'd0);
      check("t5_busy_code", 32'(code_out), 32'h03);
      gen_busy = 1'b0;
      step();
      check("t5_load_after_busy", 32'(code_load), 32'd1);
      check("t5_code_11", 32'(code_out), 32'h11);

`ifdef PHASE_CMD_ECHO_EN
      step(20);
      tx_busy = 1'b1;
      send_uart(8'h0A);
      step(3);
      check("t6_load_0a", 32'(code_out), 32'h0A);
      n0 = txs_cnt;
      step(5);
      check("t6_no_echo_busy", 32'(txs_cnt - n0), 32'd0);
      tx_busy = 1'b0;
      step();
      check("t6_tx_start", 32'(tx_start), 32'd1);
      check("t6_tx_data", 32'(tx_data), 32'h0A);
      step(10);
      check("t6_echo_once", 32'(txs_cnt - n0), 32'd1);
`else
      check("t6_no_tx_start", 32'(txs_cnt), 32'd0);
      check("t6_tx_data_zero", 32'(tx_data), 32'h00);
`endif

      step(20);
      send_uart(8'h22);
      step(3);
      check("t7_load_22", 32'(code_out), 32'h22);
      step(2);
      send_ir(8'h15);
      n0 = load_cnt;
      step(2);
      sys_rstn = 1'b0;
      #1;
      check("t7_rst_code_out", 32'(code_out), 32'h00);
      check("t7_rst_last_src", 32'(last_src), 32'd1);
      check("t7_rst_drop_cnt", 32'(drop_cnt), 32'd0);
      step(2);
      sys_rstn = 1'b1;
      step(25);
      check("t7_slots_empty", 32'(load_cnt - n0), 32'd0);
      check("t7_code_after", 32'(code_out), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
